// File: rtl/mac_pkg.sv
// Shared defaults and state encoding for the MAC accumulate stage.
package mac_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int HALF_DEF  = WIDTH_DEF / 2;
    localparam int CNT_W_DEF = 8;

    // Saturation value of the default-width operation counter.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/csel_half_adder.sv
// Half-width carry-select adder: both carry-in results are formed up front,
// cin only drives the final select.
module csel_half_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] r0;
    logic [W:0] r1;

    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

    assign {cout, sum} = cin ? r1 : r0;
endmodule

// File: rtl/mac_accumulate_stage.sv
// Resolves the multiplier's two reduced vectors into a final sum over two
// cycles (low half, then high half) and keeps the fed-back accumulator.
module mac_accumulate_stage
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec0,
    input  logic [WIDTH-1:0] in_vec1,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_flag,
    output logic [WIDTH-1:0] acc_out,
    output logic [CNT_W-1:0] op_count,
    output logic             ovf_sticky
);
    localparam int HALF = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec0_q, vec1_q;
    logic [HALF-1:0]  slo_q;
    logic             clo_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;

    logic [HALF-1:0]  lo_sum, hi_sum;
    logic             lo_c, hi_c;

    csel_half_adder #(.W(HALF)) u_lo (
        .a    (vec0_q[HALF-1:0]),
        .b    (vec1_q[HALF-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_c)
    );

    csel_half_adder #(.W(HALF)) u_hi (
        .a    (vec0_q[WIDTH-1:HALF]),
        .b    (vec1_q[WIDTH-1:HALF]),
        .cin  (clo_q),
        .sum  (hi_sum),
        .cout (hi_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec0_q   <= '0;
            vec1_q   <= '0;
            slo_q    <= '0;
            clo_q    <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    vec0_q <= in_vec0;
                    vec1_q <= in_vec1;
                end
                LO: begin
                    slo_q <= lo_sum;
                    clo_q <= lo_c;
                end
                HI: begin
                    sum_q    <= {hi_sum, slo_q};
                    carry_q  <= hi_c;
                    acc_q    <= {hi_sum, slo_q};
                    cnt_q    <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                    sticky_q <= sticky_q | hi_c;
                end
                default: ;
            endcase
            // Clear overrides the HI-state accumulator update; sum_out is untouched.
            if (acc_clear) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sum_out    = sum_q;
    assign carry_flag = carry_q;
    assign acc_out    = acc_q;
    assign op_count   = cnt_q;
    assign ovf_sticky = sticky_q;
endmodule
